// File: rtl/csh_cycle_arb_if.sv
`timescale 1ns/1ps
// csh_cycle_arb_if
// Groups the request, acknowledge and status signals of the cache cycle
// arbiter.
//   master : the requester/memory side; drives requests, MEM_ACK and its
//            qualifiers; observes grants, T-strobes and status pulses.
//   slave  : the arbiter itself.
interface csh_cycle_arb_if;
    // level requests, held until the matching grant is seen
    logic ebox_req;
    logic ebox_era_req;
    logic ebox_cca_req;
    logic chan_req;
    logic cca_req;
    // memory cycle completion and its qualifiers
    logic mem_ack;
    logic victim_dirty;
    logic page_fail;
    logic cca_cry_out;
    // registered one-hot grant pulses
    logic ebox_req_grant;
    logic ebox_era_grant;
    logic ebox_cca_grant;
    logic chan_req_grant;
    logic cca_req_grant;
    // sequencer strobes and status
    logic page_refill_t4;
    logic writeback_t2;
    logic ready_to_go;
    logic sweep_done;
    logic timeout_err;
    logic page_fail_err;

    modport master (
        output ebox_req, ebox_era_req, ebox_cca_req, chan_req, cca_req,
        output mem_ack, victim_dirty, page_fail, cca_cry_out,
        input  ebox_req_grant, ebox_era_grant, ebox_cca_grant, chan_req_grant, cca_req_grant,
        input  page_refill_t4, writeback_t2, ready_to_go,
        input  sweep_done, timeout_err, page_fail_err
    );

    modport slave (
        input  ebox_req, ebox_era_req, ebox_cca_req, chan_req, cca_req,
        input  mem_ack, victim_dirty, page_fail, cca_cry_out,
        output ebox_req_grant, ebox_era_grant, ebox_cca_grant, chan_req_grant, cca_req_grant,
        output page_refill_t4, writeback_t2, ready_to_go,
        output sweep_done, timeout_err, page_fail_err
    );
endinterface

// File: rtl/csh_cycle_arb.sv
`timescale 1ns/1ps
// csh_cycle_arb
// Cache cycle arbiter and sequencer. In IDLE it picks one pending source
// (CHAN > EBOX_ERA > EBOX_CCA > EBOX > CCA) and issues a one-cycle grant,
// then waits in BUSY for MEM_ACK. A dirty victim runs the writeback
// sequence (WB_T1, WB_T2, WB_WAIT); an EBOX page fail runs the page refill
// sequence (PR_T1..PR_T4, PR_WAIT) once and re-grants EBOX afterwards.
// Every wait-for-ack state is guarded by a TIMEOUT-cycle watchdog.
// Ports:
//   clk      cache clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      csh_cycle_arb_if.slave: requests, MEM_ACK + qualifiers in;
//            grants, PAGE_REFILL_T4, WRITEBACK_T2, READY_TO_GO and the
//            SWEEP_DONE / TIMEOUT_ERR / PAGE_FAIL_ERR pulses out
module csh_cycle_arb #(
    parameter int TIMEOUT = 64
) (
    input logic            clk,
    input logic            reset_n,
    csh_cycle_arb_if.slave bus
);

    typedef enum logic [3:0] {
        IDLE, BUSY, WB_T1, WB_T2, WB_WAIT,
        PR_T1, PR_T2, PR_T3, PR_T4, PR_WAIT, REGRANT
    } state_t;

    localparam logic [2:0] SRC_NONE     = 3'd0;
    localparam logic [2:0] SRC_EBOX     = 3'd1;
    localparam logic [2:0] SRC_EBOX_ERA = 3'd2;
    localparam logic [2:0] SRC_EBOX_CCA = 3'd3;
    localparam logic [2:0] SRC_CHAN     = 3'd4;
    localparam logic [2:0] SRC_CCA      = 3'd5;

    // last count value before the watchdog fires
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    // grant vector bit order: {cca, chan, ebox_cca, ebox_era, ebox}
    localparam logic [4:0] GNT_EBOX = 5'b00001;

    state_t     state, state_nx;
    logic [2:0] src, src_nx;
    logic [7:0] cnt, cnt_nx;
    logic       retry, retry_nx;
    logic [4:0] grant, grant_nx;
    logic       sweep, sweep_nx;
    logic       tmo, tmo_nx;
    logic       pf_err, pf_err_nx;
    logic [2:0] req_src;

    function automatic logic [2:0] pick_src(
        input logic chan, input logic era, input logic ecca,
        input logic ebox, input logic cca
    );
        if (chan)      return SRC_CHAN;
        else if (era)  return SRC_EBOX_ERA;
        else if (ecca) return SRC_EBOX_CCA;
        else if (ebox) return SRC_EBOX;
        else if (cca)  return SRC_CCA;
        return SRC_NONE;
    endfunction

    function automatic logic [4:0] grant_of(input logic [2:0] s);
        case (s)
            SRC_EBOX:     return 5'b00001;
            SRC_EBOX_ERA: return 5'b00010;
            SRC_EBOX_CCA: return 5'b00100;
            SRC_CHAN:     return 5'b01000;
            SRC_CCA:      return 5'b10000;
            default:      return 5'b00000;
        endcase
    endfunction

    assign req_src = pick_src(bus.chan_req, bus.ebox_era_req, bus.ebox_cca_req,
                              bus.ebox_req, bus.cca_req);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            src    <= SRC_NONE;
            cnt    <= 8'd0;
            retry  <= 1'b0;
            grant  <= 5'b00000;
            sweep  <= 1'b0;
            tmo    <= 1'b0;
            pf_err <= 1'b0;
        end else begin
            state  <= state_nx;
            src    <= src_nx;
            cnt    <= cnt_nx;
            retry  <= retry_nx;
            grant  <= grant_nx;
            sweep  <= sweep_nx;
            tmo    <= tmo_nx;
            pf_err <= pf_err_nx;
        end
    end

    // The counter is held at zero outside the wait states, so entering any
    // of them starts the watchdog from zero. An ack on the timeout edge is
    // checked first and therefore wins.
    always_comb begin
        state_nx  = state;
        src_nx    = src;
        cnt_nx    = 8'd0;
        retry_nx  = retry;
        grant_nx  = 5'b00000;
        sweep_nx  = 1'b0;
        tmo_nx    = 1'b0;
        pf_err_nx = 1'b0;

        case (state)
            IDLE: begin
                if (req_src != SRC_NONE) begin
                    src_nx   = req_src;
                    grant_nx = grant_of(req_src);
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                if (bus.mem_ack) begin
                    if (bus.victim_dirty) begin
                        state_nx = WB_T1;
                    end else if (bus.page_fail && src == SRC_EBOX) begin
                        if (!retry) begin
                            retry_nx = 1'b1;
                            state_nx = PR_T1;
                        end else begin
                            pf_err_nx = 1'b1;
                            state_nx  = IDLE;
                        end
                    end else begin
                        sweep_nx = (src == SRC_CCA) && bus.cca_cry_out;
                        state_nx = IDLE;
                    end
                end else if (cnt == TMO_LAST) begin
                    tmo_nx   = 1'b1;
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt + 8'd1;
                end
            end
            WB_T1: state_nx = WB_T2;
            WB_T2: state_nx = WB_WAIT;
            WB_WAIT: begin
                if (bus.mem_ack) begin
                    state_nx = IDLE;
                end else if (cnt == TMO_LAST) begin
                    tmo_nx   = 1'b1;
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt + 8'd1;
                end
            end
            PR_T1: state_nx = PR_T2;
            PR_T2: state_nx = PR_T3;
            PR_T3: state_nx = PR_T4;
            PR_T4: state_nx = PR_WAIT;
            PR_WAIT: begin
                if (bus.mem_ack) begin
                    // refill finished: replay the EBOX cycle without arbitration
                    grant_nx = GNT_EBOX;
                    state_nx = REGRANT;
                end else if (cnt == TMO_LAST) begin
                    tmo_nx   = 1'b1;
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt + 8'd1;
                end
            end
            REGRANT: state_nx = BUSY;
            default: state_nx = IDLE;
        endcase

        if (state_nx == IDLE) begin
            retry_nx = 1'b0;
        end
    end

    assign bus.ebox_req_grant = grant[0];
    assign bus.ebox_era_grant = grant[1];
    assign bus.ebox_cca_grant = grant[2];
    assign bus.chan_req_grant = grant[3];
    assign bus.cca_req_grant  = grant[4];
    assign bus.page_refill_t4 = (state == PR_T4);
    assign bus.writeback_t2   = (state == WB_T2);
    assign bus.ready_to_go    = (state == IDLE);
    assign bus.sweep_done     = sweep;
    assign bus.timeout_err    = tmo;
    assign bus.page_fail_err  = pf_err;

endmodule
